// File: rtl/motor_pkg.sv
// ============================================================================
//  Module   : motor_pkg
//  Purpose  : Phase encodings, phase-to-index decode, FSM states and fault
//             codes shared by the motor phase decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package motor_pkg;

    // Coil patterns in {A,C,B,D} bit order, listed in forward half-step order
    localparam logic [3:0] C_PH_A  = 4'b1000;
    localparam logic [3:0] C_PH_AB = 4'b1010;
    localparam logic [3:0] C_PH_B  = 4'b0010;
    localparam logic [3:0] C_PH_BC = 4'b0110;
    localparam logic [3:0] C_PH_C  = 4'b0100;
    localparam logic [3:0] C_PH_CD = 4'b0101;
    localparam logic [3:0] C_PH_D  = 4'b0001;
    localparam logic [3:0] C_PH_DA = 4'b1001;

    localparam logic [1:0] C_FAULT_NONE    = 2'b00;
    localparam logic [1:0] C_FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] C_FAULT_SKIP    = 2'b10;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    typedef struct packed {
        logic       illegal;
        logic [2:0] idx;
    } phase_dec_t;

    function automatic phase_dec_t phase_to_idx(input logic [3:0] ph);
        phase_dec_t r;
        r.illegal = 1'b0;
        r.idx     = 3'd0;
        case (ph)
            C_PH_A:  r.idx = 3'd0;
            C_PH_AB: r.idx = 3'd1;
            C_PH_B:  r.idx = 3'd2;
            C_PH_BC: r.idx = 3'd3;
            C_PH_C:  r.idx = 3'd4;
            C_PH_CD: r.idx = 3'd5;
            C_PH_D:  r.idx = 3'd6;
            C_PH_DA: r.idx = 3'd7;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/motor_phase_filter.sv
// ============================================================================
//  Module   : motor_phase_filter
//  Purpose  : 2-FF synchronizer plus stability counter; strobes accept for one
//             cycle when a new pattern has been stable for STABLE_CYCLES samples.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_phase_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] phase_in,
    output logic [3:0] pattern,
    output logic       accept
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic [3:0]       r_sync1, r_sync2, r_hold, r_pattern;
    logic [CNT_W-1:0] r_cnt;
    logic             r_accept;
    logic             w_changed;
    logic [CNT_W-1:0] w_cnt;
    logic             w_accept;

    // w_cnt is the number of consecutive equal samples including the current one
    assign w_changed = (r_sync2 != r_hold);
    assign w_cnt     = w_changed ? C_ONE :
                       (r_cnt == C_STABLE) ? r_cnt : (r_cnt + C_ONE);
    assign w_accept  = (w_cnt == C_STABLE) && (r_sync2 != r_pattern);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1   <= 4'd0;
            r_sync2   <= 4'd0;
            r_hold    <= 4'd0;
            r_pattern <= 4'd0;
            r_cnt     <= '0;
            r_accept  <= 1'b0;
        end else begin
            r_sync1  <= phase_in;
            r_sync2  <= r_sync1;
            r_hold   <= r_sync2;
            r_cnt    <= w_cnt;
            r_accept <= w_accept;
            if (w_accept) begin
                r_pattern <= r_sync2;
            end
        end
    end

    assign pattern = r_pattern;
    assign accept  = r_accept;

endmodule

`default_nettype wire

// File: rtl/motor_phase_decoder.sv
// ============================================================================
//  Module   : motor_phase_decoder
//  Purpose  : Decodes filtered coil patterns into direction, step size and a
//             signed half-step position; flags illegal patterns and skips.
//             Optional step_period output: MOTOR_PHASE_DECODER_STEP_PERIOD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_phase_decoder
    import motor_pkg::*;
#(
    parameter int POS_W         = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 20
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [3:0]              phase_in,
    input  logic                    clear,
    output logic signed [POS_W-1:0] position,
    output logic                    dir_out,
    output logic                    half_mode,
    output logic                    step_pulse,
    output logic                    locked,
    output logic                    fault,
`ifdef MOTOR_PHASE_DECODER_STEP_PERIOD_EN
    output logic [1:0]              fault_code,
    output logic [PERIOD_W-1:0]     step_period
`else
    output logic [1:0]              fault_code
`endif
);

    localparam logic signed [POS_W-1:0] C_POS_ONE = POS_W'(1);
    localparam logic signed [POS_W-1:0] C_POS_TWO = POS_W'(2);

    logic [3:0]              w_pattern;
    logic                    w_accept;
    phase_dec_t              w_dec;
    logic [2:0]              w_delta;

    state_t                  r_state, w_state_nxt;
    logic signed [POS_W-1:0] r_pos, w_pos_nxt;
    logic [2:0]              r_last_idx, w_last_nxt;
    logic                    r_dir, w_dir_nxt;
    logic                    r_half, w_half_nxt;
    logic                    r_pulse, w_pulse_nxt;
    logic [1:0]              r_code, w_code_nxt;

    motor_phase_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .nrst     (nrst),
        .phase_in (phase_in),
        .pattern  (w_pattern),
        .accept   (w_accept)
    );

    assign w_dec = phase_to_idx(w_pattern);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= ST_UNLOCKED;
            r_pos      <= '0;
            r_last_idx <= 3'd0;
            r_dir      <= 1'b0;
            r_half     <= 1'b0;
            r_pulse    <= 1'b0;
            r_code     <= C_FAULT_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_pos      <= w_pos_nxt;
            r_last_idx <= w_last_nxt;
            r_dir      <= w_dir_nxt;
            r_half     <= w_half_nxt;
            r_pulse    <= w_pulse_nxt;
            r_code     <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_last_nxt  = r_last_idx;
        w_dir_nxt   = r_dir;
        w_half_nxt  = r_half;
        w_pulse_nxt = 1'b0;
        w_code_nxt  = r_code;
        w_delta     = w_dec.idx - r_last_idx;

        // clear wins over a same-cycle accept; the event is simply dropped
        if (clear) begin
            w_state_nxt = ST_UNLOCKED;
            w_pos_nxt   = '0;
            w_code_nxt  = C_FAULT_NONE;
        end else if (w_accept) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_dec.illegal) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = C_FAULT_ILLEGAL;
                    end else begin
                        w_last_nxt  = w_dec.idx;
                        w_state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_dec.illegal) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = C_FAULT_ILLEGAL;
                    end else begin
                        case (w_delta)
                            3'd1, 3'd2, 3'd6, 3'd7: begin
                                w_pulse_nxt = 1'b1;
                                w_last_nxt  = w_dec.idx;
                                w_dir_nxt   = ~w_delta[2];
                                w_half_nxt  = w_delta[0];
                                case (w_delta)
                                    3'd1:    w_pos_nxt = r_pos + C_POS_ONE;
                                    3'd2:    w_pos_nxt = r_pos + C_POS_TWO;
                                    3'd7:    w_pos_nxt = r_pos - C_POS_ONE;
                                    default: w_pos_nxt = r_pos - C_POS_TWO;
                                endcase
                            end
                            3'd3, 3'd4, 3'd5: begin
                                w_state_nxt = ST_FAULT;
                                w_code_nxt  = C_FAULT_SKIP;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MOTOR_PHASE_DECODER_STEP_PERIOD_EN
    localparam logic [PERIOD_W-1:0] C_PER_ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_period_cnt, r_step_period;

    // Period is latched alongside the registered step_pulse it belongs to
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_period_cnt  <= '0;
            r_step_period <= '0;
        end else if (clear) begin
            r_period_cnt  <= '0;
            r_step_period <= '0;
        end else if (w_pulse_nxt) begin
            r_step_period <= r_period_cnt;
            r_period_cnt  <= C_PER_ONE;
        end else if (r_period_cnt != '1) begin
            r_period_cnt  <= r_period_cnt + C_PER_ONE;
        end
    end

    assign step_period = r_step_period;
`endif

    assign position   = r_pos;
    assign dir_out    = r_dir;
    assign half_mode  = r_half;
    assign step_pulse = r_pulse;
    assign fault_code = r_code;
    assign locked     = (r_state == ST_LOCKED);
    assign fault      = (r_state == ST_FAULT);

endmodule

`default_nettype wire
